// File: rtl/reg_file_mp_if.sv
// Register file access bus: write port, read ports, scoreboard set, bulk clear.
interface reg_file_mp_if #(
  parameter int RegAdd_WIDTH  = 5,
  parameter int RegFile_WIDTH = 32,
  parameter int NUM_RD        = 3
);
  logic                            WE;
  logic [RegAdd_WIDTH-1:0]         WA;
  logic [RegFile_WIDTH-1:0]        WD;
  logic [RegFile_WIDTH/8-1:0]      WBE;
  logic [NUM_RD*RegAdd_WIDTH-1:0]  RA;
  logic [NUM_RD*RegFile_WIDTH-1:0] RD;
  logic [NUM_RD-1:0]               RD_PEND;
  logic                            PEND_SET;
  logic [RegAdd_WIDTH-1:0]         PEND_ADDR;
  logic                            CLR_REQ;
  logic                            BUSY;

  modport master (
    output WE, WA, WD, WBE, RA, PEND_SET, PEND_ADDR, CLR_REQ,
    input  RD, RD_PEND, BUSY
  );

  modport slave (
    input  WE, WA, WD, WBE, RA, PEND_SET, PEND_ADDR, CLR_REQ,
    output RD, RD_PEND, BUSY
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enabled writes, optional write-to-read
// bypass, hardwired zero register, pending-write scoreboard and bulk-clear engine.
module reg_file_mp #(
  parameter int RegAdd_WIDTH  = 5,
  parameter int RegFile_WIDTH = 32,
  parameter int RegFile_DEPTH = 32,
  parameter int NUM_RD        = 3,
  parameter int BYPASS        = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic          CLK,
  input  logic          RST,
  reg_file_mp_if.slave  bus
);
  localparam int AW = RegAdd_WIDTH;
  localparam int DW = RegFile_WIDTH;
  localparam int NB = RegFile_WIDTH / 8;
  localparam logic [AW:0] DepthL  = (AW+1)'(RegFile_DEPTH);
  localparam logic [AW:0] LastIdx = (AW+1)'(RegFile_DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  logic [DW-1:0]            mem_q [RegFile_DEPTH];
  logic [RegFile_DEPTH-1:0] pend_q;
  logic [AW:0]              idx_q;  // one extra bit so DEPTH == 2**AW cannot alias
  state_e                   state_q;

  logic we_ok;
  logic set_ok;
  logic [NUM_RD*DW-1:0] rd_flat;
  logic [NUM_RD-1:0]    pend_flat;

  // Address is backed by a writable register (in range and not the zero register).
  function automatic logic addr_ok(logic [AW-1:0] a);
    return ({1'b0, a} < DepthL) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign we_ok  = bus.WE && addr_ok(bus.WA) && (state_q == StIdle);
  assign set_ok = bus.PEND_SET && addr_ok(bus.PEND_ADDR);

  // Storage, scoreboard and clear sequencer; reset overrides a clear in progress.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int r = 0; r < RegFile_DEPTH; r++) mem_q[r] <= '0;
      pend_q  <= '0;
      idx_q   <= '0;
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          for (int r = 0; r < RegFile_DEPTH; r++) begin
            if (we_ok && bus.WA == AW'(r)) begin
              for (int b = 0; b < NB; b++) begin
                if (bus.WBE[b]) mem_q[r][8*b +: 8] <= bus.WD[8*b +: 8];
              end
              pend_q[r] <= 1'b0;
            end
            // Set is assigned after clear so a same-cycle set wins.
            if (set_ok && bus.PEND_ADDR == AW'(r)) pend_q[r] <= 1'b1;
          end
          // Clear request overrides any scoreboard update from this cycle.
          if (bus.CLR_REQ) begin
            pend_q  <= '0;
            idx_q   <= '0;
            state_q <= StClear;
          end
        end
        StClear: begin
          for (int r = 0; r < RegFile_DEPTH; r++) begin
            if (idx_q == (AW+1)'(r)) mem_q[r] <= '0;
          end
          idx_q <= idx_q + 1'b1;
          if (idx_q == LastIdx) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Zero-latency reads with per-port bypass of the in-flight write.
  always_comb begin
    logic [AW-1:0] ra;
    logic [DW-1:0] data;
    rd_flat   = '0;
    pend_flat = '0;
    ra        = '0;
    data      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra   = bus.RA[k*AW +: AW];
      data = '0;
      for (int r = 0; r < RegFile_DEPTH; r++) begin
        if (ra == AW'(r) && addr_ok(ra)) begin
          data         = mem_q[r];
          pend_flat[k] = pend_q[r];
        end
      end
      if ((BYPASS != 0) && we_ok && (bus.WA == ra)) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.WBE[b]) data[8*b +: 8] = bus.WD[8*b +: 8];
        end
      end
      rd_flat[k*DW +: DW] = data;
    end
  end

  assign bus.RD      = rd_flat;
  assign bus.RD_PEND = pend_flat;
  assign bus.BUSY    = (state_q == StClear);
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: vector table plus hand-written scoreboard, clear and reset sequences.
module tb_reg_file_mp;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  reg_file_mp_if #(.RegAdd_WIDTH(AW), .RegFile_WIDTH(DW), .NUM_RD(NR)) bus ();
  reg_file_mp_if #(.RegAdd_WIDTH(AW), .RegFile_WIDTH(DW), .NUM_RD(NR)) bus16 ();

  reg_file_mp #(
    .RegAdd_WIDTH(AW), .RegFile_WIDTH(DW), .RegFile_DEPTH(32),
    .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  reg_file_mp #(
    .RegAdd_WIDTH(AW), .RegFile_WIDTH(DW), .RegFile_DEPTH(16),
    .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)
  ) dut16 (
    .CLK(CLK),
    .RST(RST),
    .bus(bus16)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic            we;
    logic [4:0]      wa;
    logic [31:0]     wd;
    logic [3:0]      wbe;
    logic [2:0][4:0] ra;
    logic [2:0][31:0] exp;
  } vec_t;
  vec_t vt[$];

  task automatic push(input string nm, input logic [31:0] e);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    exp_t x;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
    end else begin
      x = sb.pop_front();
      if (act !== x.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
      end
    end
  endtask

  function automatic logic [31:0] rd(input int k);
    return bus.RD[k*DW +: DW];
  endfunction

  function automatic logic [31:0] rd16(input int k);
    return bus16.RD[k*DW +: DW];
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in;
    bus.WE = 0; bus.WA = '0; bus.WD = '0; bus.WBE = '0; bus.RA = '0;
    bus.PEND_SET = 0; bus.PEND_ADDR = '0; bus.CLR_REQ = 0;
    bus16.WE = 0; bus16.WA = '0; bus16.WD = '0; bus16.WBE = '0; bus16.RA = '0;
    bus16.PEND_SET = 0; bus16.PEND_ADDR = '0; bus16.CLR_REQ = 0;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus.RA = {a2, a1, a0};
  endtask

  task automatic add_vec(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] wbe, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.wbe = wbe;
    v.ra = {a2, a1, a0};
    v.exp = {e2, e1, e0};
    vt.push_back(v);
  endtask

  initial begin
    int n;
    idle_in();

    // Expected read data is checked combinationally before the edge that commits the write.
    add_vec(1, 5, 32'hDEADBEEF, 4'hF, 5, 0, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    add_vec(1, 5, 32'h0000AA00, 4'h2, 5, 1, 2, 32'hDEADAAEF, 0, 0);
    add_vec(0, 0, 32'h0,        4'h0, 5, 5, 0, 32'hDEADAAEF, 32'hDEADAAEF, 0);
    add_vec(1, 7, 32'h12345678, 4'hF, 7, 0, 7, 32'h12345678, 0, 32'h12345678);
    add_vec(1, 0, 32'hFFFFFFFF, 4'hF, 0, 7, 5, 0, 32'h12345678, 32'hDEADAAEF);
    add_vec(0, 0, 32'h0,        4'h0, 0, 7, 31, 0, 32'h12345678, 0);
    add_vec(1, 31, 32'hA5A5A5A5, 4'h5, 31, 31, 6, 32'h00A500A5, 32'h00A500A5, 0);
    add_vec(1, 31, 32'hFFFFFFFF, 4'h0, 31, 0, 0, 32'h00A500A5, 0, 0);
    add_vec(0, 0, 32'h0,        4'h0, 31, 5, 7, 32'h00A500A5, 32'hDEADAAEF, 32'h12345678);

    // Reset
    tick(); tick();
    RST = 1'b1;
    set_ra(1, 5, 31);
    #1;
    for (int k = 0; k < NR; k++) push("reset_rd", 0);
    for (int k = 0; k < NR; k++) pop_cmp(rd(k));
    push("reset_pend", 0); pop_cmp(32'(bus.RD_PEND));
    push("reset_busy", 0); pop_cmp(32'(bus.BUSY));

    // Vector table
    foreach (vt[i]) begin
      bus.WE = vt[i].we; bus.WA = vt[i].wa; bus.WD = vt[i].wd; bus.WBE = vt[i].wbe;
      bus.RA = vt[i].ra;
      #1;
      for (int k = 0; k < NR; k++) push($sformatf("vec%0d_rd%0d", i, k), vt[i].exp[k]);
      for (int k = 0; k < NR; k++) pop_cmp(rd(k));
      tick();
    end
    idle_in();

    // Scoreboard
    bus.PEND_SET = 1; bus.PEND_ADDR = 9; set_ra(9, 5, 9);
    #1; push("pend_before_edge", 0); pop_cmp(32'(bus.RD_PEND));
    tick();
    bus.PEND_SET = 0;
    #1; push("pend_set", 32'b101); pop_cmp(32'(bus.RD_PEND));
    bus.WE = 1; bus.WA = 9; bus.WD = 32'h99; bus.WBE = 4'hF;
    #1; push("pend_not_bypassed", 32'b101); pop_cmp(32'(bus.RD_PEND));
    push("bypass_rd9", 32'h99); pop_cmp(rd(0));
    tick();
    bus.WE = 0;
    #1; push("pend_cleared", 0); pop_cmp(32'(bus.RD_PEND));
    bus.WE = 1; bus.WA = 9; bus.PEND_SET = 1; bus.PEND_ADDR = 9;
    tick();
    idle_in(); set_ra(9, 5, 9);
    #1; push("pend_set_wins", 32'b101); pop_cmp(32'(bus.RD_PEND));
    bus.PEND_SET = 1; bus.PEND_ADDR = 0; set_ra(0, 0, 0);
    tick();
    bus.PEND_SET = 0;
    #1; push("pend_zero_ignored", 0); pop_cmp(32'(bus.RD_PEND));

    // Bulk clear
    for (int r = 1; r < 32; r++) begin
      bus.WE = 1; bus.WA = 5'(r); bus.WD = 32'h1000_0000 | 32'(r); bus.WBE = 4'hF;
      tick();
    end
    idle_in();
    bus.PEND_SET = 1; bus.PEND_ADDR = 12;
    tick();
    bus.CLR_REQ = 1; bus.PEND_SET = 1; bus.PEND_ADDR = 3;
    bus.WE = 1; bus.WA = 2; bus.WD = 32'h2222; bus.WBE = 4'hF;
    tick();
    idle_in(); set_ra(9, 12, 3);
    #1; push("clear_pend_zero", 0); pop_cmp(32'(bus.RD_PEND));
    push("clear_partial_rd", 32'h1000_000C); pop_cmp(rd(1));
    n = 0;
    while (bus.BUSY === 1'b1 && n < 100) begin
      bus.WE = (n == 0 || n == 20); bus.WA = 3; bus.WD = 32'hFFFFFFFF; bus.WBE = 4'hF;
      set_ra(3, 12, 3);
      if (n == 0) begin
        #1; push("clear_no_bypass", 32'h1000_0003); pop_cmp(rd(0));
      end
      n++;
      tick();
    end
    idle_in();
    push("busy_cycles", 32); pop_cmp(32'(n));
    for (int r = 0; r < 32; r++) begin
      set_ra(5'(r), 9, 12);
      #1; push($sformatf("cleared_rd%0d", r), 0); pop_cmp(rd(0));
    end
    push("cleared_pend", 0); pop_cmp(32'(bus.RD_PEND));

    // Reset in the middle of a clear
    bus.WE = 1; bus.WA = 20; bus.WD = 32'h2020; bus.WBE = 4'hF;
    tick();
    bus.WE = 0; bus.CLR_REQ = 1;
    tick();
    bus.CLR_REQ = 0;
    for (int i = 0; i < 10; i++) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    set_ra(20, 4, 0);
    #1; push("rst_mid_busy", 0); pop_cmp(32'(bus.BUSY));
    push("rst_mid_rd20", 0); pop_cmp(rd(0));
    bus.WE = 1; bus.WA = 4; bus.WD = 32'h44; bus.WBE = 4'hF;
    tick();
    bus.WE = 0;
    #1; push("rst_then_write", 32'h44); pop_cmp(rd(1));

    // Depth-16 instance
    bus16.WE = 1; bus16.WA = 20; bus16.WD = 32'hBAD; bus16.WBE = 4'hF;
    bus16.RA = {5'd20, 5'd15, 5'd20};
    bus16.PEND_SET = 1; bus16.PEND_ADDR = 20;
    #1; push("d16_bypass_oob", 0); pop_cmp(rd16(0));
    tick();
    bus16.WA = 15; bus16.WD = 32'h15; bus16.PEND_SET = 0;
    tick();
    bus16.WE = 0;
    #1; push("d16_rd_oob", 0); pop_cmp(rd16(0));
    push("d16_rd15", 32'h15); pop_cmp(rd16(1));
    push("d16_pend_oob", 0); pop_cmp(32'(bus16.RD_PEND));
    bus16.CLR_REQ = 1;
    tick();
    bus16.CLR_REQ = 0;
    n = 0;
    while (bus16.BUSY === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    push("d16_busy_cycles", 16); pop_cmp(32'(n));
    #1; push("d16_cleared_rd15", 0); pop_cmp(rd16(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
